// File: rtl/dmem.sv
// dmem: byte-addressed, word-organised data memory for the MEM stage.
// Word index is addr[log2(DEPTH)+1:2]. Upper address bits wrap and byte offset bits are ignored.
// Per-lane write mask. The array is not reset, so it can be preloaded hierarchically.
// Optional macro DMEM_OUT_REG_EN: registered read data with one cycle of latency.
// By default the read is combinational.
module dmem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    RD,
   input  logic                    WR,
   input  logic [31:0]             addr,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] byte_en,
   output logic [DATA_WIDTH-1:0]   data_out
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH-1:0];
   logic [IDX_W-1:0]      idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_addr;

   // Word select; byte offset and bits above the array size play no part
   assign idx         = addr[IDX_W+1:2];
   assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0]};
   assign rd_word     = mem[idx];

   // Lane-masked write; dropped entirely while reset is low
   always_ff @(posedge clk) begin
      if (rst_n && WR) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (byte_en[i]) begin
               mem[idx][8*i +: 8] <= data_in[8*i +: 8];
            end
         end
      end
   end

`ifdef DMEM_OUT_REG_EN
   // Registered read captures pre-write contents on a same-edge write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out <= '0;
      end else begin
         data_out <= RD ? rd_word : '0;
      end
   end
`else
   // Combinational read, forced to zero when idle or in reset
   always_comb begin
      data_out = '0;
      if (rst_n && RD) begin
         data_out = rd_word;
      end
   end
`endif

endmodule

// File: tb/tb_dmem.sv
// Scoreboard bench for dmem: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_dmem;

   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int NB    = DW / 8;
`ifdef DMEM_OUT_REG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          RD      = 1'b0;
   logic          WR      = 1'b0;
   logic [31:0]   addr    = '0;
   logic [DW-1:0] data_in = '0;
   logic [NB-1:0] byte_en = '0;
   logic [DW-1:0] data_out;

   dmem #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .RD(RD), .WR(WR), .addr(addr),
      .data_in(data_in), .byte_en(byte_en), .data_out(data_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model [DEPTH];

   typedef struct {
      logic [DW-1:0] val;
      int            due;
      string         tag;
   } exp_t;
   exp_t q[$];

   task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // One cycle of stimulus: expected read is the word as it stands before this edge's write
   task automatic issue(input string tag, input bit rst, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      int   w;
      exp_t e;
      rst_n = rst; RD = rd; WR = wr; addr = a; data_in = d; byte_en = be;
      w     = (a / 4) % DEPTH;
      e.val = (rst && rd) ? model[w] : '0;
      e.due = cyc + LAT;
      e.tag = tag;
      q.push_back(e);
      if (rst && wr)
         for (int b = 0; b < NB; b++)
            if (be[b]) model[w][8*b +: 8] = d[8*b +: 8];
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare whatever is due this cycle; a registered output is zero whenever reset is low
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].due < cyc) begin
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL stale_%s: got no sample want due cycle %0d", e.tag, e.due);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         check(e.tag, data_out, rst_n ? e.val : '0);
      end
   end

   initial begin
      logic [31:0] a;
      bit          rst;
      for (int i = 0; i < DEPTH; i++) begin
         model[i]   = $urandom();
         dut.mem[i] = model[i];
      end
      @(posedge clk); #1;

      // Contents survive reset
      model[3]   = 32'h11223344;
      dut.mem[3] = 32'h11223344;
      issue("rst_low_read", 1'b0, 1'b1, 1'b0, 32'hC, '0, '0);
      issue("rst_low_read2", 1'b0, 1'b1, 1'b0, 32'hC, '0, '0);
      issue("preload_kept", 1'b1, 1'b1, 1'b0, 32'hC, '0, '0);

      // Full word write then read
      issue("wr_full", 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      issue("rd_full", 1'b1, 1'b1, 1'b0, 32'h10, '0, '0);
      check("mem4_full", dut.mem[4], 32'hDEADBEEF);

      // Byte and halfword merges
      issue("wr_byte", 1'b1, 1'b0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100);
      check("mem4_byte", dut.mem[4], 32'hDEAABEEF);
      issue("wr_half", 1'b1, 1'b1, 1'b1, 32'h10, 32'h00001234, 4'b0011);
      check("mem4_half", dut.mem[4], 32'hDEAA1234);
      issue("wr_noop", 1'b1, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
      issue("rd_merged", 1'b1, 1'b1, 1'b0, 32'h10, '0, '0);

      // Wrap and alignment
      issue("wr_wrap", 1'b1, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
      check("mem0_wrap", dut.mem[0], 32'hCAFEF00D);
      issue("rd_unaligned", 1'b1, 1'b1, 1'b0, 32'h3, '0, '0);
      issue("rd_off", 1'b1, 1'b0, 1'b0, 32'h3, '0, '0);

      // Write held across an edge in reset is dropped
      issue("rst_write", 1'b0, 1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF);
      check("mem4_rst", dut.mem[4], 32'hDEAA1234);
      issue("rd_after_rst", 1'b1, 1'b1, 1'b0, 32'h10, '0, '0);

      // Read-during-write to the same word
      issue("wr_zero", 1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 4'hF);
      issue("rdw_old", 1'b1, 1'b1, 1'b1, 32'h8, 32'h1, 4'hF);
      issue("rdw_new", 1'b1, 1'b1, 1'b0, 32'h8, '0, '0);

      // Back-to-back writes to one word
      issue("b2b_0", 1'b1, 1'b1, 1'b1, 32'h20, 32'h000000A1, 4'b0001);
      issue("b2b_1", 1'b1, 1'b1, 1'b1, 32'h21, 32'h0000B200, 4'b0010);
      issue("b2b_2", 1'b1, 1'b1, 1'b1, 32'h22, 32'hC3000000, 4'b1000);
      issue("b2b_rd", 1'b1, 1'b1, 1'b0, 32'h20, '0, '0);

      // Randomised traffic, biased to a few words so writes and reads collide
      for (int n = 0; n < 600; n++) begin
         a = $urandom();
         if ($urandom_range(0, 2) != 0) a[9:6] = 4'h0;
         rst = ($urandom_range(0, 40) != 0);
         issue("rand", rst, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               a, $urandom(), 4'($urandom_range(0, 15)));
      end

      // Drain
      issue("idle0", 1'b1, 1'b0, 1'b0, '0, '0, '0);
      issue("idle1", 1'b1, 1'b0, 1'b0, '0, '0, '0);
      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
